// File: rtl/bram_fifo_ctrl_1024x16.sv
// FIFO controller wrapping a 1-write/1-read port BRAM with 1-cycle registered read latency.
// A 2-entry output buffer hides the read latency and presents first-word-fall-through data.
module bram_fifo_ctrl_1024x16 #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   count,
    output logic          mem_ce0,
    output logic          mem_we0,
    output logic [AW-1:0] mem_a0,
    output logic [DW-1:0] mem_d0,
    output logic          mem_ce1,
    output logic [AW-1:0] mem_a1,
    input  logic [DW-1:0] mem_q1
);

    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] mem_cnt_q, mem_cnt_d;
    logic          inflight_q;
    logic [1:0]    obuf_cnt_q, obuf_cnt_d, obuf_after;
    logic [DW-1:0] ob0_q, ob0_d, ob1_q, ob1_d;
    logic          push, pop_out, pop_mem;

    always_comb begin
        in_ready   = rstn && (mem_cnt_q < CW'(DEPTH));
        push       = in_valid && in_ready;
        out_valid  = (obuf_cnt_q != 2'd0);
        pop_out    = out_valid && out_ready;
        obuf_after = obuf_cnt_q - {1'b0, pop_out};
        // Only issue a read if the buffer has room for it once the current read lands.
        pop_mem    = (mem_cnt_q != '0) && ((obuf_after + {1'b0, inflight_q}) < 2'd2);

        mem_ce0 = push;
        mem_we0 = push;
        mem_a0  = wptr_q;
        mem_d0  = in_data;
        mem_ce1 = pop_mem;
        mem_a1  = rptr_q;

        out_data = ob0_q;
        count    = mem_cnt_q + CW'(inflight_q) + CW'(obuf_cnt_q);
    end

    always_comb begin
        mem_cnt_d = mem_cnt_q;
        if (push && !pop_mem) begin
            mem_cnt_d = mem_cnt_q + CW'(1);
        end else if (!push && pop_mem) begin
            mem_cnt_d = mem_cnt_q - CW'(1);
        end

        ob0_d = ob0_q;
        ob1_d = ob1_q;
        if (pop_out && (obuf_cnt_q == 2'd2)) begin
            ob0_d = ob1_q;
        end
        // Captured word goes behind whatever survives this cycle's pop.
        if (inflight_q) begin
            if (obuf_after == 2'd0) begin
                ob0_d = mem_q1;
            end else begin
                ob1_d = mem_q1;
            end
        end
        obuf_cnt_d = obuf_after + {1'b0, inflight_q};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
            obuf_cnt_q <= 2'd0;
            ob0_q      <= '0;
            ob1_q      <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_mem) begin
                rptr_q <= rptr_q + AW'(1);
            end
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= pop_mem;
            obuf_cnt_q <= obuf_cnt_d;
            ob0_q      <= ob0_d;
            ob1_q      <= ob1_d;
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl_1024x16.sv
// Scoreboard bench for bram_fifo_ctrl_1024x16 with a behavioural BRAM and a queue reference.
module tb_bram_fifo_ctrl_1024x16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [10:0] count;
    logic        mem_ce0, mem_we0, mem_ce1;
    logic [9:0]  mem_a0, mem_a1;
    logic [15:0] mem_d0;
    logic [15:0] mem_q1;

    int n_vec = 0, n_err = 0;
    int n_push = 0, n_pop = 0, n_wr = 0, n_rd = 0;
    int model_cnt = 0;
    logic [15:0] sb[$];
    logic        armed = 1'b0;
    logic [15:0] held;
    logic [15:0] bram [1024];

    always #5 clk = ~clk;

    bram_fifo_ctrl_1024x16 dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .mem_ce0(mem_ce0), .mem_we0(mem_we0), .mem_a0(mem_a0), .mem_d0(mem_d0),
        .mem_ce1(mem_ce1), .mem_a1(mem_a1), .mem_q1(mem_q1)
    );

    always @(posedge clk) begin
        if (mem_ce0 && mem_we0) bram[mem_a0] <= mem_d0;
        if (mem_ce1) mem_q1 <= bram[mem_a1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every comparison against the queue model happens away from the clock edge.
    always @(negedge clk) begin
        if (!rstn) begin
            sb.delete();
            model_cnt = 0;
            armed = 1'b0;
            n_wr = 0;
            n_rd = 0;
        end else begin
            check("count", 32'(count), 32'(model_cnt));
            check("ce0_vs_handshake", 32'(mem_ce0), 32'(in_valid && in_ready));
            if (out_valid && model_cnt == 0) check("valid_when_empty", 32'(out_valid), 32'(0));
            if (mem_ce0) begin
                check("we0", 32'(mem_we0), 32'(1));
                check("wr_addr", 32'(mem_a0), 32'(n_wr % 1024));
                check("wr_data", 32'(mem_d0), 32'(in_data));
                n_wr++;
            end
            if (mem_ce1) begin
                check("rd_addr", 32'(mem_a1), 32'(n_rd % 1024));
                if (mem_ce0) check("addr_collision", 32'(mem_a0 == mem_a1), 32'(0));
                n_rd++;
            end
            if (armed && out_valid) check("hold_stable", 32'(out_data), 32'(held));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("pop_from_empty_model", 32'(1), 32'(0));
                end else begin
                    check("order", 32'(out_data), 32'(sb.pop_front()));
                    model_cnt--;
                end
                n_pop++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                model_cnt++;
                n_push++;
            end
            armed = out_valid && !out_ready;
            held  = out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input int base, input bit rnd);
        int  v = 0;
        bit  acc;
        in_valid = 1'b1;
        for (int c = 0; c < 4 * n + 100 && v < n; c++) begin
            in_data = rnd ? 16'($urandom) : 16'(base + v);
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) v++;
        end
        in_valid = 1'b0;
        check("push_n_done", 32'(v), 32'(n));
    endtask

    task automatic wait_valid(input int limit);
        for (int c = 0; c < limit && !out_valid; c++) step();
        check("wait_valid", 32'(out_valid), 32'(1));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3000 && count != 0; c++) step();
        step();
        check("drain_empty", 32'(count), 32'(0));
        check("drain_no_valid", 32'(out_valid), 32'(0));
        out_ready = 1'b0;
    endtask

    initial begin
        int p0, q0;

        // Reset values.
        #2;
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_ce", 32'({mem_ce0, mem_we0, mem_ce1}), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        step();
        rstn = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'(1));
        step();

        // Single word latency: accepted at edge N, visible after N+2.
        in_valid = 1'b1;
        in_data  = 16'hA5A5;
        step();
        in_valid = 1'b0;
        check("lat_after_n", 32'(out_valid), 32'(0));
        step();
        check("lat_after_n1", 32'(out_valid), 32'(0));
        step();
        check("lat_after_n2", 32'(out_valid), 32'(1));
        check("lat_data", 32'(out_data), 32'(16'hA5A5));
        check("lat_count", 32'(count), 32'(1));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pop_count", 32'(count), 32'(0));
        check("pop_valid", 32'(out_valid), 32'(0));

        // Fill to DEPTH+2 with the consumer stalled; further writes must be refused.
        push_n(1026, 1, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        p0 = n_push;
        repeat (20) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'(0));
            check("full_no_write", 32'(mem_ce0), 32'(0));
            step();
        end
        in_valid = 1'b0;
        check("full_count", 32'(count), 32'(1026));
        check("full_no_accept", 32'(n_push - p0), 32'(0));
        drain();

        // Streaming: one word per cycle once the pipeline is primed.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        p0 = n_push;
        for (int c = 0; c < 6000 && (n_push - p0) < 5000; c++) begin
            in_data = 16'($urandom);
            if (c == 50) q0 = n_pop;
            if (c == 1050) check("throughput", 32'(n_pop - q0), 32'(1000));
            step();
        end
        in_valid = 1'b0;
        check("stream_done", 32'(n_push - p0), 32'(5000));
        drain();

        // Random handshakes on both sides.
        p0 = n_push;
        for (int c = 0; c < 50000 && (n_push - p0) < 20000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        check("random_done", 32'(n_push - p0), 32'(20000));
        drain();

        // One resident word, simultaneous push and pop.
        push_n(1, 16'h1111, 1'b0);
        wait_valid(10);
        check("single_head", 32'(out_data), 32'(16'h1111));
        check("single_count", 32'(count), 32'(1));
        in_valid  = 1'b1;
        in_data   = 16'h2222;
        out_ready = 1'b1;
        @(negedge clk);
        check("simul_head", 32'(out_data), 32'(16'h1111));
        check("simul_in_ready", 32'(in_ready), 32'(1));
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_valid(10);
        check("simul_next", 32'(out_data), 32'(16'h2222));
        drain();

        // Reset while a read is in flight.
        push_n(37, 0, 1'b1);
        repeat (3) step();
        check("pre_rst_count", 32'(count), 32'(37));
        in_valid  = 1'b1;
        in_data   = 16'($urandom);
        out_ready = 1'b1;
        @(negedge clk);
        check("read_issue", 32'(mem_ce1), 32'(1));
        step();
        rstn = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check("mid_rst_count", 32'(count), 32'(0));
        check("mid_rst_in_ready", 32'(in_ready), 32'(0));
        check("mid_rst_ce", 32'({mem_ce0, mem_ce1}), 32'(0));
        check("mid_rst_out_data", 32'(out_data), 32'(0));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rstn     = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        step();
        in_valid = 1'b0;
        wait_valid(10);
        check("post_rst_data", 32'(out_data), 32'(16'h1234));
        check("post_rst_count", 32'(count), 32'(1));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
